z80_bus_bridge: RTL and testbench

Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

---
 rtl/z80_bridge_pkg.sv | 37 +++
 rtl/z80_bus_bridge.sv | 156 +++++++++++++++
 tb/tb_z80_bus_bridge.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bridge_pkg.sv
// Shared definitions for the Z80 bus bridge: FSM states, default parameters
// and the bus-cycle decode used to classify what the CPU is doing.
package z80_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WRSP = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    localparam int         DEFAULT_TIMEOUT    = 255;
    localparam logic [7:0] DEFAULT_FLOAT_DATA = 8'hFF;

    typedef struct packed {
        logic mem;
        logic io;
        logic intack;
    } bus_cycle_t;

    // Refresh is excluded from the memory term by nRFSH; intack is told apart from I/O by nM1.
    function automatic bus_cycle_t decode_cycle(
        input logic n_mreq,
        input logic n_iorq,
        input logic n_rd,
        input logic n_wr,
        input logic n_m1,
        input logic n_rfsh
    );
        bus_cycle_t cyc;
        cyc.mem    = !n_mreq && n_rfsh && (!n_rd || !n_wr);
        cyc.io     = !n_iorq && n_m1 && (!n_rd || !n_wr);
        cyc.intack = !n_m1 && !n_iorq;
        return cyc;
    endfunction

endpackage

// File: rtl/z80_bus_bridge.sv
// Bridges Z80 memory/I/O bus cycles onto a valid/ready request and response
// backend, stretching the CPU with nWAIT and aborting stalled cycles.
module z80_bus_bridge
    import z80_bridge_pkg::*;
#(
    parameter int         TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [7:0] FLOAT_DATA = DEFAULT_FLOAT_DATA
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_wr,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    input  logic        nRFSH,
    output logic [7:0]  D_rd,
    output logic        D_oe,
    output logic        nWAIT,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic        req_io,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic [7:0]  int_vector,
    output logic        err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    bridge_state_t state;
    bridge_state_t state_next;
    bus_cycle_t    cyc;

    logic [7:0]  cnt;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_we;
    logic        lat_io;
    logic [7:0]  d_rd_q;
    logic        err_q;

    logic start_req;
    logic take_intack;
    logic complete;
    logic timeout;
    logic cnt_last;
    logic bus_idle;

    assign cyc      = decode_cycle(nMREQ, nIORQ, nRD, nWR, nM1, nRFSH);
    assign cnt_last = (cnt == CNT_LAST);
    assign bus_idle = nRD && nWR && nIORQ;

    // Completion wins over timeout when both land in the same cycle.
    always_comb begin
        state_next  = state;
        start_req   = 1'b0;
        take_intack = 1'b0;
        complete    = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (cyc.mem || cyc.io) begin
                    state_next = REQ;
                    start_req  = 1'b1;
                end else if (cyc.intack) begin
                    state_next  = DONE;
                    take_intack = 1'b1;
                end
            end
            REQ: begin
                if (req_ready && rsp_valid) begin
                    state_next = DONE;
                    complete   = 1'b1;
                end else if (cnt_last) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end else if (req_ready) begin
                    state_next = WRSP;
                end
            end
            WRSP: begin
                if (rsp_valid) begin
                    state_next = DONE;
                    complete   = 1'b1;
                end else if (cnt_last) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            DONE: begin
                if (bus_idle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_io    <= 1'b0;
            d_rd_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= timeout;
            if (start_req) begin
                cnt       <= '0;
                lat_addr  <= A;
                lat_wdata <= D_wr;
                lat_we    <= !nWR;
                lat_io    <= !nIORQ;
            end else if (state == REQ || state == WRSP) begin
                cnt <= cnt + 8'd1;
            end

            if (take_intack) begin
                d_rd_q <= int_vector;
            end else if (timeout) begin
                d_rd_q <= FLOAT_DATA;
            end else if (complete && !lat_we) begin
                d_rd_q <= rsp_rdata;
            end
        end
    end

    assign req_valid = (state == REQ);
    assign req_we    = req_valid && lat_we;
    assign req_io    = req_valid && lat_io;
    assign req_addr  = lat_addr;
    assign req_wdata = lat_wdata;

    // Gated by nRESET so the CPU is released the instant reset asserts.
    assign nWAIT = !(nRESET && (cyc.mem || cyc.io) && (state != DONE));
    assign D_oe  = (state == DONE) && (!nRD || cyc.intack);
    assign D_rd  = d_rd_q;
    assign err   = err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Self-checking bench for z80_bus_bridge: two instances (long and short
// timeout) driven with directed and random bus cycles against a cycle-count model.
module tb_z80_bus_bridge;

    localparam int         T_A   = 255;
    localparam int         T_B   = 4;
    localparam logic [7:0] FLOAT = 8'hFF;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [15:0] A;
    logic [7:0]  D_wr;
    logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
    logic        req_ready, rsp_valid;
    logic [7:0]  rsp_rdata, int_vector;

    logic [1:0][7:0]  d_rd;
    logic [1:0]       d_oe, n_wait, req_valid, req_we, req_io, err;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata;

    int         checks = 0;
    int         errors = 0;
    int         tmo [2] = '{T_A, T_B};
    logic [7:0] exp_drd [2];

    // Current transaction: ready arrives tx_r cycles into REQ, response tx_s cycles later.
    int          tx_r, tx_s;
    bit          tx_read, tx_io, tx_spur;
    logic [15:0] tx_addr;
    logic [7:0]  tx_wdata, tx_rdata;

    always #5 CLK = ~CLK;

    z80_bus_bridge #(.TIMEOUT(T_A), .FLOAT_DATA(FLOAT)) dut_a (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_wr(D_wr),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH),
        .D_rd(d_rd[0]), .D_oe(d_oe[0]), .nWAIT(n_wait[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready), .req_we(req_we[0]), .req_io(req_io[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .int_vector(int_vector), .err(err[0])
    );

    z80_bus_bridge #(.TIMEOUT(T_B), .FLOAT_DATA(FLOAT)) dut_b (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_wr(D_wr),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH),
        .D_rd(d_rd[1]), .D_oe(d_oe[1]), .nWAIT(n_wait[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready), .req_we(req_we[1]), .req_io(req_io[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .int_vector(int_vector), .err(err[1])
    );

    task automatic checkOutput(input string tag, input int inst,
                               input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s dut%0d: observed %h expected %h", tag, inst, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input int inst, input logic observed, input logic expected);
        checkOutput(tag, inst, {15'b0, observed}, {15'b0, expected});
    endtask

    task automatic checkByte(input string tag, input int inst, input logic [7:0] observed, input logic [7:0] expected);
        checkOutput(tag, inst, {8'b0, observed}, {8'b0, expected});
    endtask

    // Model: transaction completes iff ready+response land within TIMEOUT counted cycles.
    function automatic bit timedOut(input int t);
        return (tx_r + tx_s) >= t;
    endfunction

    function automatic int doneStart(input int t);
        int c;
        c = tx_r + tx_s;
        return ((c < t) ? c : t - 1) + 2;
    endfunction

    function automatic int lastReqCycle(input int t);
        return ((tx_r < t) ? tx_r : t - 1) + 1;
    endfunction

    task automatic setIdle();
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
        req_ready = 1'b0; rsp_valid = 1'b0;
        rsp_rdata = 8'($urandom);
        int_vector = 8'($urandom);
    endtask

    task automatic setTx(input bit rd, input bit io, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int r, input int s, input bit spur);
        tx_read = rd; tx_io = io; tx_addr = addr; tx_wdata = wdata;
        tx_rdata = rdata; tx_r = r; tx_s = s; tx_spur = spur;
    endtask

    task automatic applyStimulus(input int j, input bit active);
        int k;
        k = j - 1;
        setIdle();
        if (active) begin
            nMREQ = tx_io;
            nIORQ = !tx_io;
            nRD   = !tx_read;
            nWR   = tx_read;
            A     = tx_addr;
            D_wr  = tx_wdata;
            req_ready = (k == tx_r);
            rsp_valid = (k == tx_r + tx_s) || (tx_spur && k == tx_r - 1);
            if (k == tx_r + tx_s) rsp_rdata = tx_rdata;
        end
    endtask

    task automatic checkBusCycle(input int j, input bit active);
        int ds;
        bit rv;
        for (int i = 0; i < 2; i++) begin
            ds = doneStart(tmo[i]);
            rv = active && j >= 1 && j <= lastReqCycle(tmo[i]);
            if (active && j == ds)
                exp_drd[i] = timedOut(tmo[i]) ? FLOAT : (tx_read ? tx_rdata : exp_drd[i]);
            checkBit("nWAIT", i, n_wait[i], !(active && j < ds));
            checkBit("req_valid", i, req_valid[i], rv);
            checkBit("req_we", i, req_we[i], rv && !tx_read);
            checkBit("req_io", i, req_io[i], rv && tx_io);
            if (rv) begin
                checkOutput("req_addr", i, req_addr[i], tx_addr);
                checkByte("req_wdata", i, req_wdata[i], tx_wdata);
            end
            checkBit("err", i, err[i], active && timedOut(tmo[i]) && j == ds);
            checkBit("D_oe", i, d_oe[i], active && j >= ds && tx_read);
            checkByte("D_rd", i, d_rd[i], exp_drd[i]);
        end
    endtask

    task automatic runTransaction();
        int rel;
        rel = (doneStart(T_A) > doneStart(T_B)) ? doneStart(T_A) : doneStart(T_B);
        rel = rel + 1 + int'($urandom_range(1));
        for (int j = 0; j <= rel + 1; j++) begin
            @(posedge CLK); #1;
            applyStimulus(j, j < rel);
            @(negedge CLK);
            checkBusCycle(j, j < rel);
        end
    endtask

    task automatic runIntack(input logic [7:0] vec, input int hold);
        bit active;
        for (int j = 0; j <= hold + 1; j++) begin
            @(posedge CLK); #1;
            active = (j < hold);
            setIdle();
            int_vector = vec;
            if (active) begin
                nM1 = 1'b0;
                nIORQ = 1'b0;
            end
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (active && j == 1) exp_drd[i] = vec;
                checkBit("intack_nWAIT", i, n_wait[i], 1'b1);
                checkBit("intack_req_valid", i, req_valid[i], 1'b0);
                checkBit("intack_err", i, err[i], 1'b0);
                checkBit("intack_D_oe", i, d_oe[i], active && j >= 1);
                checkByte("intack_D_rd", i, d_rd[i], exp_drd[i]);
            end
        end
    endtask

    task automatic runRefresh(input int len);
        for (int j = 0; j <= len; j++) begin
            @(posedge CLK); #1;
            setIdle();
            if (j < len) begin
                nMREQ = 1'b0;
                nRFSH = 1'b0;
                nRD   = j[0];
                A     = 16'($urandom);
            end
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                checkBit("rfsh_nWAIT", i, n_wait[i], 1'b1);
                checkBit("rfsh_req_valid", i, req_valid[i], 1'b0);
                checkBit("rfsh_D_oe", i, d_oe[i], 1'b0);
                checkByte("rfsh_D_rd", i, d_rd[i], exp_drd[i]);
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkBit({tag, "_nWAIT"}, i, n_wait[i], 1'b1);
            checkBit({tag, "_req_valid"}, i, req_valid[i], 1'b0);
            checkBit({tag, "_req_we"}, i, req_we[i], 1'b0);
            checkBit({tag, "_req_io"}, i, req_io[i], 1'b0);
            checkBit({tag, "_D_oe"}, i, d_oe[i], 1'b0);
            checkBit({tag, "_err"}, i, err[i], 1'b0);
            checkByte({tag, "_D_rd"}, i, d_rd[i], 8'h00);
            checkOutput({tag, "_req_addr"}, i, req_addr[i], 16'h0000);
            checkByte({tag, "_req_wdata"}, i, req_wdata[i], 8'h00);
        end
    endtask

    // Drives a long read, asserts reset mid-cycle at bus cycle at_j and checks the instant effect.
    task automatic runResetMid(input int r, input int at_j);
        setTx(1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom), r, 40, 1'b0);
        for (int j = 0; j < at_j; j++) begin
            @(posedge CLK); #1;
            applyStimulus(j, 1'b1);
            @(negedge CLK);
            checkBusCycle(j, 1'b1);
        end
        @(posedge CLK); #1;
        applyStimulus(at_j, 1'b1);
        #1 nRESET = 1'b0;
        #1;
        exp_drd[0] = 8'h00;
        exp_drd[1] = 8'h00;
        checkResetState("rst_mid");
        @(posedge CLK); #1;
        setIdle();
        @(negedge CLK);
        checkResetState("rst_hold");
        nRESET = 1'b1;
    endtask

    initial begin
        nRESET = 1'b0;
        A = 16'h0000;
        D_wr = 8'h00;
        setIdle();
        exp_drd[0] = 8'h00;
        exp_drd[1] = 8'h00;
        repeat (2) @(negedge CLK);
        checkResetState("reset");
        nRESET = 1'b1;

        $display("[TB] memory read 1234, ready after 2, response after 3 more");
        setTx(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5, 2, 3, 1'b0);
        runTransaction();

        $display("[TB] I/O write 00FE with same-cycle ready and response");
        setTx(1'b0, 1'b1, 16'h00FE, 8'h3C, 8'h00, 0, 0, 1'b0);
        runTransaction();

        $display("[TB] interrupt acknowledge with vector FF");
        runIntack(8'hFF, 3);

        $display("[TB] stalled ready, short-timeout instance aborts");
        setTx(1'b1, 1'b0, 16'h4000, 8'h00, 8'h5A, 10, 0, 1'b0);
        runTransaction();

        $display("[TB] timeout boundaries");
        setTx(1'b1, 1'b0, 16'h8001, 8'h00, 8'h66, 3, 0, 1'b0);
        runTransaction();
        setTx(1'b1, 1'b1, 16'h0042, 8'h00, 8'h77, 1, 2, 1'b1);
        runTransaction();
        setTx(1'b0, 1'b0, 16'hC000, 8'h99, 8'h00, 2, 2, 1'b0);
        runTransaction();

        $display("[TB] refresh cycles");
        runRefresh(4);

        $display("[TB] reset during WRSP and during REQ");
        runResetMid(0, 3);
        setTx(1'b1, 1'b0, 16'h2222, 8'h00, 8'h3E, 1, 1, 1'b0);
        runTransaction();
        runResetMid(5, 3);
        setTx(1'b1, 1'b0, 16'h3333, 8'h00, 8'hC3, 0, 2, 1'b0);
        runTransaction();

        $display("[TB] random transactions");
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(7) == 0) begin
                runIntack(8'($urandom), 2 + int'($urandom_range(2)));
            end else begin
                setTx(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(6)), int'($urandom_range(6)), 1'($urandom));
                runTransaction();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
